// File: rtl/hall_commutator.sv
// Hall-sensor commutator: synchronises and deglitches three hall inputs, decodes them into
// registered phase drive, and tracks faults, signed steps, commutation period and stall.
module hall_commutator #(
  parameter int FILTER_CYCLES = 4,
  parameter int PERIOD_WIDTH  = 16,
  parameter int STALL_CYCLES  = 50000,
  parameter int STEP_WIDTH    = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [2:0]                   hall,
  input  logic                         en,
  input  logic                         dir,
  input  logic                         brake,
  input  logic                         fault_clr,
  output logic [2:0]                   u,
  output logic [2:0]                   z,
  output logic                         hall_fault,
  output logic                         stall,
  output logic [PERIOD_WIDTH-1:0]      period,
  output logic                         period_valid,
  output logic signed [STEP_WIDTH-1:0] steps
);

  localparam logic [7:0]              FILT_LIM  = 8'(FILTER_CYCLES);
  localparam logic [PERIOD_WIDTH-1:0] STALL_LIM = PERIOD_WIDTH'(STALL_CYCLES);
  localparam logic [PERIOD_WIDTH-1:0] CNT_MAX   = {PERIOD_WIDTH{1'b1}};
  localparam logic [PERIOD_WIDTH-1:0] CNT_ONE   = {{(PERIOD_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [STEP_WIDTH-1:0]   STEP_ONE  = {{(STEP_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2:0]              IDX_BAD   = 3'd7;

  // Position of a code in the forward rotation; 000/111 map to IDX_BAD.
  function automatic logic [2:0] seq_index(input logic [2:0] code);
    case (code)
      3'b101:  seq_index = 3'd0;
      3'b100:  seq_index = 3'd1;
      3'b110:  seq_index = 3'd2;
      3'b010:  seq_index = 3'd3;
      3'b011:  seq_index = 3'd4;
      3'b001:  seq_index = 3'd5;
      default: seq_index = IDX_BAD;
    endcase
  endfunction

  function automatic logic [2:0] idx_next(input logic [2:0] idx);
    idx_next = (idx == 3'd5) ? 3'd0 : idx + 3'd1;
  endfunction

  function automatic logic [2:0] idx_prev(input logic [2:0] idx);
    idx_prev = (idx == 3'd0) ? 3'd5 : idx - 3'd1;
  endfunction

  // Forward drive as {u, z}.
  function automatic logic [5:0] fwd_drive(input logic [2:0] code);
    case (code)
      3'b101:  fwd_drive = 6'b100_001;
      3'b100:  fwd_drive = 6'b100_010;
      3'b110:  fwd_drive = 6'b010_100;
      3'b010:  fwd_drive = 6'b010_001;
      3'b011:  fwd_drive = 6'b001_010;
      3'b001:  fwd_drive = 6'b001_100;
      default: fwd_drive = 6'b000_111;
    endcase
  endfunction

  logic [2:0]              sync_a_r;
  logic [2:0]              hall_sync_r;
  logic [2:0]              h_f_r;
  logic                    h_ok_r;
  logic [2:0]              cand_r;
  logic [7:0]              filt_cnt_r;
  logic [PERIOD_WIDTH-1:0] per_cnt_r;
  logic                    ref_ok_r;

  logic [7:0]              filt_next_s;
  logic                    accept_s;
  logic [2:0]              prev_idx_s;
  logic [2:0]              new_idx_s;
  logic                    step_fwd_s;
  logic                    step_rev_s;
  logic                    step_s;
  logic                    neutral_s;
  logic                    jump_fault_s;
  logic                    fault_set_s;
  logic                    stall_hit_s;
  logic [5:0]              fwd_s;
  logic [2:0]              u_next_s;
  logic [2:0]              z_next_s;

  // Two-flop synchroniser for the asynchronous hall pins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_a_r    <= 3'b000;
      hall_sync_r <= 3'b000;
    end else begin
      sync_a_r    <= hall;
      hall_sync_r <= sync_a_r;
    end
  end

  // Deglitch count: a differing code must hold for FILTER_CYCLES samples in a row.
  always_comb begin
    filt_next_s = 8'd0;
    accept_s    = 1'b0;
    if (hall_sync_r == h_f_r) begin
      filt_next_s = 8'd0;
    end else begin
      if ((filt_cnt_r != 8'd0) && (hall_sync_r == cand_r)) begin
        filt_next_s = filt_cnt_r + 8'd1;
      end else begin
        filt_next_s = 8'd1;
      end
      accept_s = (filt_next_s == FILT_LIM);
    end
  end

  // Classify each accepted code against the previous filtered code.
  always_comb begin
    prev_idx_s   = seq_index(h_f_r);
    new_idx_s    = seq_index(hall_sync_r);
    step_fwd_s   = 1'b0;
    step_rev_s   = 1'b0;
    neutral_s    = 1'b0;
    jump_fault_s = 1'b0;
    if (accept_s) begin
      if (!h_ok_r || (prev_idx_s == IDX_BAD)) begin
        neutral_s = 1'b1;
      end else if (new_idx_s == IDX_BAD) begin
        jump_fault_s = 1'b1;
      end else if (new_idx_s == idx_next(prev_idx_s)) begin
        step_fwd_s = 1'b1;
      end else if (new_idx_s == idx_prev(prev_idx_s)) begin
        step_rev_s = 1'b1;
      end else begin
        jump_fault_s = 1'b1;
      end
    end else begin
      neutral_s = 1'b0;
    end
    step_s      = step_fwd_s | step_rev_s;
    fault_set_s = jump_fault_s | (h_ok_r & (prev_idx_s == IDX_BAD));
    stall_hit_s = (per_cnt_r == STALL_LIM);
  end

  // Filter state, accepted code and step counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cand_r     <= 3'b000;
      filt_cnt_r <= 8'd0;
      h_f_r      <= 3'b000;
      h_ok_r     <= 1'b0;
      steps      <= '0;
    end else begin
      cand_r     <= hall_sync_r;
      filt_cnt_r <= accept_s ? 8'd0 : filt_next_s;
      if (accept_s) begin
        h_f_r  <= hall_sync_r;
        h_ok_r <= 1'b1;
      end
      if (step_fwd_s) begin
        steps <= steps + STEP_ONE;
      end else if (step_rev_s) begin
        steps <= steps - STEP_ONE;
      end
    end
  end

  // Sticky fault; a simultaneous set beats the clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hall_fault <= 1'b0;
    end else if (fault_set_s) begin
      hall_fault <= 1'b1;
    end else if (fault_clr) begin
      hall_fault <= 1'b0;
    end
  end

  // Period measurement and stall: a stall invalidates the reference so the
  // step that ends it reports no period.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      per_cnt_r    <= '0;
      ref_ok_r     <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
      stall        <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      if (accept_s) begin
        per_cnt_r <= CNT_ONE;
      end else if (per_cnt_r != CNT_MAX) begin
        per_cnt_r <= per_cnt_r + CNT_ONE;
      end
      if (step_s) begin
        if (ref_ok_r && !stall_hit_s) begin
          period       <= per_cnt_r;
          period_valid <= 1'b1;
        end
        ref_ok_r <= 1'b1;
        stall    <= 1'b0;
      end else if (neutral_s) begin
        ref_ok_r <= 1'b0;
      end else if (stall_hit_s && !accept_s) begin
        stall    <= 1'b1;
        ref_ok_r <= 1'b0;
      end
    end
  end

  // Drive selection; reverse energises the phase that forward leaves low.
  always_comb begin
    fwd_s    = fwd_drive(h_f_r);
    u_next_s = 3'b000;
    z_next_s = 3'b111;
    if (hall_fault || !en || !h_ok_r || (prev_idx_s == IDX_BAD)) begin
      u_next_s = 3'b000;
      z_next_s = 3'b111;
    end else if (brake) begin
      u_next_s = 3'b000;
      z_next_s = 3'b000;
    end else if (!dir) begin
      u_next_s = fwd_s[5:3];
      z_next_s = fwd_s[2:0];
    end else begin
      u_next_s = ~(fwd_s[5:3] | fwd_s[2:0]);
      z_next_s = fwd_s[2:0];
    end
  end

  // Registered phase outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      u <= 3'b000;
      z <= 3'b111;
    end else begin
      u <= u_next_s;
      z <= z_next_s;
    end
  end

endmodule

// File: tb/tb_hall_commutator.sv
// Directed bench for hall_commutator: expectations are queued as stimulus is driven and
// popped when the corresponding outputs are sampled on the falling edge.
module tb_hall_commutator;

  localparam int FC = 4;
  localparam int PW = 16;
  localparam int SC = 1000;
  localparam int SW = 16;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [2:0]           hall;
  logic                 en;
  logic                 dir;
  logic                 brake;
  logic                 fault_clr;
  logic [2:0]           u;
  logic [2:0]           z;
  logic                 hall_fault;
  logic                 stall;
  logic [PW-1:0]        period;
  logic                 period_valid;
  logic signed [SW-1:0] steps;

  always #5 clk = ~clk;

  hall_commutator #(
    .FILTER_CYCLES(FC),
    .PERIOD_WIDTH (PW),
    .STALL_CYCLES (SC),
    .STEP_WIDTH   (SW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .hall        (hall),
    .en          (en),
    .dir         (dir),
    .brake       (brake),
    .fault_clr   (fault_clr),
    .u           (u),
    .z           (z),
    .hall_fault  (hall_fault),
    .stall       (stall),
    .period      (period),
    .period_valid(period_valid),
    .steps       (steps)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] pv_obs[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  // Record every period strobe with the value it carried.
  always @(negedge clk) begin
    if (period_valid === 1'b1) pv_obs.push_back(32'(period));
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sb_push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    exp_t e;
    n_tests++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $error("FAIL sb_empty: observed %0h with nothing expected", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
      end
    end
  endtask

  function automatic logic [31:0] next_pv();
    if (pv_obs.size() == 0) return 32'hFFFF_FFFF;
    return pv_obs.pop_front();
  endfunction

  logic [2:0] rot_code [6] = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};
  logic [2:0] rot_u    [6] = '{3'b100, 3'b010, 3'b010, 3'b001, 3'b001, 3'b100};
  logic [2:0] rot_z    [6] = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};

  initial begin
    rst_n = 1'b0; hall = 3'b000; en = 1'b1; dir = 1'b0; brake = 1'b0; fault_clr = 1'b0;
    cycles(3);
    sb_push("rst_u", 32'd0);     sb_push("rst_z", 32'd7);     sb_push("rst_fault", 32'd0);
    sb_push("rst_stall", 32'd0); sb_push("rst_period", 32'd0); sb_push("rst_pv", 32'd0);
    sb_push("rst_steps", 32'd0);
    sb_check(u); sb_check(z); sb_check(hall_fault); sb_check(stall);
    sb_check(period); sb_check(period_valid); sb_check(32'(steps));

    // First code: visible exactly on the FC+3 th edge.
    rst_n = 1'b1; hall = 3'b101;
    sb_push("lat_early_u", 32'd0);
    cycles(FC + 2);
    sb_check(u);
    sb_push("lat_u", 32'b100); sb_push("lat_z", 32'b001);
    sb_push("lat_steps", 32'd0); sb_push("lat_fault", 32'd0); sb_push("lat_pv_cnt", 32'd0);
    cycles(1);
    sb_check(u); sb_check(z); sb_check(32'(steps)); sb_check(hall_fault); sb_check(pv_obs.size());

    // Forward rotation, 100 cycles per code.
    for (int i = 0; i < 6; i++) begin
      hall = rot_code[i];
      sb_push($sformatf("rot%0d_u", i), 32'(rot_u[i]));
      sb_push($sformatf("rot%0d_z", i), 32'(rot_z[i]));
      cycles(100);
      sb_check(u); sb_check(z);
    end
    sb_push("rot_steps", 32'd6); sb_push("rot_pv_cnt", 32'd5);
    sb_check(32'(steps)); sb_check(pv_obs.size());
    for (int i = 0; i < 5; i++) begin
      sb_push($sformatf("rot_period%0d", i), 32'd100);
      sb_check(next_pv());
    end

    // 3-cycle glitch is rejected, 4-cycle pulse is accepted.
    hall = 3'b100; cycles(3); hall = 3'b101;
    sb_push("glitch_u", 32'b100); sb_push("glitch_z", 32'b001); sb_push("glitch_steps", 32'd6);
    cycles(10);
    sb_check(u); sb_check(z); sb_check(32'(steps));
    pv_obs.delete();
    hall = 3'b100; cycles(4); hall = 3'b101;
    sb_push("pulse_z", 32'b010); sb_push("pulse_steps", 32'd7);
    cycles(3);
    sb_check(z); sb_check(32'(steps));
    sb_push("pulse_back_z", 32'b001); sb_push("pulse_back_steps", 32'd6);
    sb_push("pulse_pv_cnt", 32'd2);
    cycles(10);
    sb_check(z); sb_check(32'(steps)); sb_check(pv_obs.size());
    sb_push("pulse_period", 32'd4);
    void'(next_pv());
    sb_check(next_pv());

    // Skipped step 101 -> 110 faults; clear resumes drive one cycle later.
    hall = 3'b110;
    sb_push("skip_fault", 32'd1); sb_push("skip_u", 32'd0); sb_push("skip_z", 32'd7);
    sb_push("skip_steps", 32'd6);
    cycles(8);
    sb_check(hall_fault); sb_check(u); sb_check(z); sb_check(32'(steps));
    fault_clr = 1'b1; cycles(1); fault_clr = 1'b0;
    sb_push("clr_fault", 32'd0); sb_push("clr_u_hold", 32'd0);
    sb_check(hall_fault); sb_check(u);
    sb_push("resume_u", 32'b010); sb_push("resume_z", 32'b100);
    cycles(1);
    sb_check(u); sb_check(z);

    // Invalid 111 faults and a clear cannot remove it while present.
    hall = 3'b111;
    sb_push("h111_fault", 32'd1); sb_push("h111_u", 32'd0); sb_push("h111_z", 32'd7);
    cycles(8);
    sb_check(hall_fault); sb_check(u); sb_check(z);
    fault_clr = 1'b1; cycles(1); fault_clr = 1'b0;
    sb_push("h111_clr_blocked", 32'd1);
    sb_check(hall_fault);
    hall = 3'b110; cycles(8);
    fault_clr = 1'b1; cycles(1); fault_clr = 1'b0;
    sb_push("h111_recover_fault", 32'd0); sb_push("h111_recover_u", 32'b010);
    cycles(1);
    sb_check(hall_fault); sb_check(u);

    // Reverse step to 100, then dir / brake / en priorities.
    hall = 3'b100; cycles(FC + 2);
    sb_push("rev_u", 32'b100); sb_push("rev_z", 32'b010); sb_push("rev_steps", 32'd5);
    cycles(2);
    sb_check(u); sb_check(z); sb_check(32'(steps));
    dir = 1'b1;
    sb_push("dir1_u", 32'b001); sb_push("dir1_z", 32'b010);
    cycles(1);
    sb_check(u); sb_check(z);
    brake = 1'b1;
    sb_push("brake_u", 32'd0); sb_push("brake_z", 32'd0);
    cycles(1);
    sb_check(u); sb_check(z);
    brake = 1'b0; en = 1'b0;
    sb_push("en0_u", 32'd0); sb_push("en0_z", 32'd7);
    cycles(1);
    sb_check(u); sb_check(z);
    en = 1'b1; dir = 1'b0;
    sb_push("en1_u", 32'b100);
    cycles(1);
    sb_check(u);

    // Stall after SC cycles without an accept (6 edges since the accept so far).
    pv_obs.delete();
    sb_push("stall_before", 32'd0);
    cycles(SC - 7);
    sb_check(stall);
    sb_push("stall_at", 32'd1);
    cycles(1);
    sb_check(stall);
    hall = 3'b110;
    sb_push("stall_clear", 32'd0); sb_push("stall_steps", 32'd6); sb_push("stall_pv_cnt", 32'd0);
    sb_push("stall_u", 32'b010);
    cycles(8);
    sb_check(stall); sb_check(32'(steps)); sb_check(pv_obs.size()); sb_check(u);

    // Reset mid-run.
    rst_n = 1'b0;
    sb_push("mid_rst_u", 32'd0); sb_push("mid_rst_z", 32'd7); sb_push("mid_rst_steps", 32'd0);
    sb_push("mid_rst_period", 32'd0); sb_push("mid_rst_fault", 32'd0);
    sb_push("mid_rst_stall", 32'd0); sb_push("mid_rst_pv", 32'd0);
    cycles(1);
    sb_check(u); sb_check(z); sb_check(32'(steps)); sb_check(period);
    sb_check(hall_fault); sb_check(stall); sb_check(period_valid);
    rst_n = 1'b1;
    sb_push("post_rst_u", 32'b010); sb_push("post_rst_z", 32'b100); sb_push("post_rst_steps", 32'd0);
    cycles(FC + 3);
    sb_check(u); sb_check(z); sb_check(32'(steps));

    sb_push("sb_drained", 32'd0);
    sb_check(sb_q.size() - 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
